// File: rtl/lane_swapper.sv
// lane_swapper: permutes a DATA_W-bit word at LANE_W-bit lane granularity on a
// valid/ready stream. The mode is chosen per beat: pass, swap adjacent lanes,
// reverse lane order, or reverse every bit. A main register plus one skid entry
// keep full throughput with a registered in_ready. A saturating counter tracks
// accepted beats for debug.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_data   input word
//   in_mode   per-beat mode (00 pass, 01 lane swap, 10 lane reverse, 11 bit reverse)
//   in_valid  producer has a beat
//   in_ready  block can accept a beat (registered)
//   out_data  permuted word
//   out_valid out_data is valid
//   out_ready consumer accepts the beat
//   beat_cnt  saturating count of accepted beats
//   cnt_clr   synchronous clear of beat_cnt (wins over a same-cycle accept)
module lane_swapper #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANE_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_cnt,
  input  logic              cnt_clr
);

  localparam int unsigned NUM_LANES = DATA_W / LANE_W;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_SWAP   = 2'b01;
  localparam logic [1:0] MODE_REV    = 2'b10;
  localparam logic [1:0] MODE_BITREV = 2'b11;

  // Lane swap needs lanes in pairs.
  if ((DATA_W % (2 * LANE_W)) != 0) begin : g_param_check
    $error("lane_swapper: DATA_W must be a multiple of 2*LANE_W");
  end

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              ready_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] perm_c;
  logic              accept_c;
  logic              emit_c;

  assign accept_c = in_valid & ready_q;
  assign emit_c   = main_valid_q & out_ready;

  // Permutation of the incoming beat, applied at acceptance.
  always_comb begin
    perm_c = in_data;
    case (in_mode)
      MODE_PASS: perm_c = in_data;
      MODE_SWAP: begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
          perm_c[k*LANE_W +: LANE_W] = in_data[(k ^ 32'd1)*LANE_W +: LANE_W];
        end
      end
      MODE_REV: begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
          perm_c[k*LANE_W +: LANE_W] = in_data[(NUM_LANES-1-k)*LANE_W +: LANE_W];
        end
      end
      MODE_BITREV: begin
        for (int unsigned i = 0; i < DATA_W; i++) begin
          perm_c[i] = in_data[DATA_W-1-i];
        end
      end
      default: perm_c = in_data;
    endcase
  end

  // Main/skid next state. Accept is impossible while the skid entry is full,
  // so the skid-to-main move never collides with a new beat.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (emit_c) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_d = perm_c;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      if (!main_valid_q) begin
        main_d       = perm_c;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = perm_c;
        skid_valid_d = 1'b1;
      end
    end
  end

  // Saturating beat counter; clear wins over a same-cycle accept.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = main_valid_q;
  assign in_ready  = ready_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_lane_swapper.sv
// Testbench for lane_swapper: directed cases plus random traffic on an 8-bit
// instance checked by a scoreboard, and directed cases on 16-bit instances
// (nibble lanes with a 4-bit counter, byte lanes).
module tb_lane_swapper;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance under scoreboard
  logic [7:0]  in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] beat_cnt;
  logic        cnt_clr = 1'b0;

  // Shared stimulus for the 16-bit instances
  logic [15:0] s_data = '0;
  logic [1:0]  s_mode = '0;
  logic        s_valid = 1'b0;
  logic        s_clr = 1'b0;
  logic        s_out_ready = 1'b1;
  logic        a_ready, a_valid, b_ready, b_valid;
  logic [15:0] a_data, b_data;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;

  lane_swapper #(.DATA_W(8), .LANE_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .beat_cnt(beat_cnt),
    .cnt_clr(cnt_clr)
  );

  lane_swapper #(.DATA_W(16), .LANE_W(4), .CNT_W(4)) u_nib16 (
    .clk(clk), .reset(reset), .in_data(s_data), .in_mode(s_mode),
    .in_valid(s_valid), .in_ready(a_ready), .out_data(a_data),
    .out_valid(a_valid), .out_ready(s_out_ready), .beat_cnt(a_cnt),
    .cnt_clr(s_clr)
  );

  lane_swapper #(.DATA_W(16), .LANE_W(8), .CNT_W(16)) u_byte16 (
    .clk(clk), .reset(reset), .in_data(s_data), .in_mode(s_mode),
    .in_valid(s_valid), .in_ready(b_ready), .out_data(b_data),
    .out_valid(b_valid), .out_ready(s_out_ready), .beat_cnt(b_cnt),
    .cnt_clr(s_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference permutation computed lane-by-lane from the mode rules.
  function automatic logic [63:0] ref_perm(input logic [63:0] d, input logic [1:0] m,
                                           input int dw, input int lw);
    logic [63:0] r;
    logic [63:0] mask;
    int n;
    int src;
    r = '0;
    mask = (64'd1 << lw) - 64'd1;
    n = dw / lw;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'b01:   src = (k % 2 == 0) ? k + 1 : k - 1;
        2'b10:   src = n - 1 - k;
        default: src = k;
      endcase
      r |= ((d >> (src * lw)) & mask) << (k * lw);
    end
    if (m == 2'b11) begin
      r = '0;
      for (int i = 0; i < dw; i++) r[i] = d[dw - 1 - i];
    end
    return r;
  endfunction

  // Scoreboard state: expected outputs, buffered-beat occupancy, counter model.
  logic [7:0]  exp_q[$];
  int          occ = 0;
  logic [15:0] m_cnt = '0;

  always @(negedge reset) begin
    exp_q.delete();
    occ = 0;
    m_cnt = '0;
  end

  // Monitor + scoreboard, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (reset) begin
      logic acc;
      logic emit;
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      check("sb_in_ready", 64'(in_ready), 64'(occ < 2));
      check("sb_out_valid", 64'(out_valid), 64'(occ > 0));
      check("sb_beat_cnt", 64'(beat_cnt), 64'(m_cnt));
      if (emit) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_out: got %0h expected none at %0t", out_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("sb_out_data", 64'(out_data), 64'(e));
        end
      end
      if (acc) exp_q.push_back(8'(ref_perm(64'(in_data), in_mode, 8, 4)));
      occ = occ + (acc ? 1 : 0) - (emit ? 1 : 0);
      if (cnt_clr) m_cnt = '0;
      else if (acc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_out;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_beat_cnt", 64'(beat_cnt), 64'd0);
    reset = 1'b1;

    // Basic 8-bit beats, one-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h71; in_mode = 2'b01;
    step();
    check("dir_71_valid", 64'(out_valid), 64'd1);
    check("dir_71", 64'(out_data), 64'h17);
    in_data = 8'hB4; in_mode = 2'b01;
    step();
    check("dir_b4", 64'(out_data), 64'h4B);
    in_data = 8'hA5; in_mode = 2'b00;
    step();
    check("dir_a5", 64'(out_data), 64'hA5);
    in_valid = 1'b0;
    step();
    check("dir_idle_valid", 64'(out_valid), 64'd0);

    // Back-pressure: only two beats buffer
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01; in_data = 8'h11;
    step();
    check("bp_ready_after_1", 64'(in_ready), 64'd1);
    in_data = 8'h22;
    step();
    check("bp_ready_after_2", 64'(in_ready), 64'd0);
    in_data = 8'h33;
    step();
    check("bp_hold_data", 64'(out_data), 64'h11);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    step();
    check("bp_hold_data2", 64'(out_data), 64'h11);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_second", 64'(out_data), 64'h22);
    check("bp_ready_rise", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_third", 64'(out_data), 64'h33);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Throughput: 20 back-to-back beats
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      in_mode = 2'($urandom);
      check("tp_in_ready", 64'(in_ready), 64'd1);
      step();
      if (out_valid) n_out++;
    end
    in_valid = 1'b0;
    check("tp_outputs", 64'(n_out), 64'd20);
    check("tp_beat_cnt", 64'(beat_cnt), 64'd20);
    step();

    // 16-bit permutations
    s_valid = 1'b1; s_data = 16'hABCD; s_mode = 2'b01;
    step();
    check("w16_swap", 64'(a_data), 64'hBADC);
    s_mode = 2'b10;
    step();
    check("w16_rev", 64'(a_data), 64'hDCBA);
    s_mode = 2'b11;
    step();
    check("w16_bitrev", 64'(a_data), 64'hB3D5);
    s_data = 16'h1234; s_mode = 2'b01;
    step();
    check("w16_byteswap", 64'(b_data), 64'h3412);

    // Counter saturation on the 4-bit counter
    s_valid = 1'b0; s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    check("cnt_cleared", 64'(a_cnt), 64'd0);
    s_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      s_data = 16'($urandom);
      s_mode = 2'($urandom);
      step();
      if (i == 13) check("cnt_14", 64'(a_cnt), 64'd14);
    end
    check("cnt_saturated", 64'(a_cnt), 64'd15);
    s_clr = 1'b1;
    step();
    check("cnt_clr_priority", 64'(a_cnt), 64'd0);
    s_clr = 1'b0; s_valid = 1'b0;
    step();
    check("cnt_clr_stays0", 64'(a_cnt), 64'd0);

    // Random traffic under the scoreboard
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom % 3) != 0;
      cnt_clr   = ($urandom % 50) == 0;
      step();
    end
    in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with the skid entry full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A; in_mode = 2'b10;
    step();
    in_data = 8'h3C; in_mode = 2'b11;
    step();
    in_valid = 1'b0;
    check("rst_skid_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hF0; in_mode = 2'b01;
    step();
    in_valid = 1'b0;
    check("rst_after_f0", 64'(out_data), 64'h0F);
    check("rst_after_cnt", 64'(beat_cnt), 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_swapper.md
Name: lane_swapper

Overview:
Parametrised successor to the 8-bit nibble swapper. Permutes a DATA_W-bit word at LANE_W-bit lane granularity, with the mode selected per beat: pass, adjacent-lane swap, lane reversal or full bit reversal. It sits on a valid/ready stream between producer and consumer, and a two-entry skid buffer sustains full throughput with a registered in_ready. A saturating counter records accepted beats for debug.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of 2*LANE_W.
LANE_W, 4, lane width in bits; 4 gives a nibble, 8 gives a byte.
CNT_W, 16, width of the beat counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset. Asserted when 0, released synchronously to clk by the integrator.
in_data  input  DATA_W  input word.
in_mode  input  2  per-beat mode: 00 pass, 01 swap adjacent lanes, 10 reverse lane order, 11 bit-reverse whole word.
in_valid  input  1  producer has a beat.
in_ready  output  1  block can accept a beat; registered.
out_data  output  DATA_W  permuted word.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts the beat.
beat_cnt  output  CNT_W  count of accepted input beats; saturating.
cnt_clr  input  1  synchronous clear of beat_cnt.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, in_ready=1, beat_cnt=0, skid entry empty. A reset mid-stream drops all held beats.
- Permutation, with N=DATA_W/LANE_W lanes and lane k = bits [k*LANE_W +: LANE_W]:
  - 00: out = in.
  - 01: lanes 2j and 2j+1 exchanged for every j.
  - 10: out lane k = in lane N-1-k.
  - 11: out bit i = in bit DATA_W-1-i.
- The permutation is applied at acceptance. The mode is sampled with its beat, so mode changes between beats have no cross-effect.
- Accept: in_valid & in_ready at a rising edge. Emit: out_valid & out_ready at a rising edge.
- Latency: an accepted beat appears on out_data/out_valid on the next cycle when the main register is empty or emitting.
- Main register:
  - Loads on accept when it is empty, or when it emits in the same cycle and the skid entry is empty.
  - Otherwise the accepted beat goes into the skid entry.
- Skid entry: when the main register emits while the skid entry is full, the skid beat moves to main. A simultaneous new accept is impossible because in_ready=0.
- in_ready = skid entry empty, registered. in_ready falls the cycle after a beat enters the skid entry and rises the cycle after it drains.
- Hold: while out_valid=1 and out_ready=0, out_data is stable and out_valid stays high.
- No beat is dropped or duplicated, and order is preserved.
- Full throughput: with out_ready held at 1, one beat per cycle passes.
- Sustained stall: at most 2 beats are buffered (main plus skid); the third is refused via in_ready=0.
- beat_cnt:
  - Increments by 1 on each accept and saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 forces 0 and takes priority over a same-cycle accept, which is then not counted.
- Parameter check: elaboration fails if DATA_W % (2*LANE_W) != 0.

Test Plan:
- Defaults: release reset. Send 0x71 mode 01 -> 0x17 one cycle later. Send 0xB4 mode 01 -> 0x4B. Send 0xA5 mode 00 -> 0xA5.
- DATA_W=16, LANE_W=4: 0xABCD with mode 01 -> 0xBADC, mode 10 -> 0xDCBA, mode 11 -> 0xB3D5. DATA_W=16, LANE_W=8: 0x1234 with mode 01 -> 0x3412.
- Back-pressure: hold out_ready=0 and present 0x11, 0x22, 0x33 at mode 01. Only 0x11 and 0x22 are accepted; in_ready=0 from the cycle after the second accept. Release out_ready -> 0x11, 0x22 emitted, then 0x33 accepted and emitted as 0x33, in order.
- Throughput: 20 beats with in_valid=1 and out_ready=1 -> 20 outputs on 20 consecutive cycles, in_ready constant 1, beat_cnt=20.
- Counter: CNT_W=4, 18 accepts -> beat_cnt=15, saturated. Assert cnt_clr in a cycle that also accepts -> beat_cnt=0.
- Reset mid-operation: with the skid full, pull reset low asynchronously between edges -> out_valid=0, in_ready=1, beat_cnt=0 immediately. After release, send 0xF0 mode 01 -> 0x0F.
